// File: rtl/tile_seq_pkg.sv
// Shared state encoding for the tile sequencer FSM.
package tile_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BUF = 3'd1,
    SWAP     = 3'd2,
    RUN      = 3'd3,
    FINISH   = 3'd4,
    ABORT    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// RUN-phase watchdog: counts enabled cycles since clear and flags the limit cycle.
module seq_watchdog #(
  parameter int unsigned TIMEOUT_W = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] cnt;
  logic [TIMEOUT_W:0]   cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (enable && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

  // cnt holds completed RUN cycles, so the current cycle is number cnt+1
  assign cnt_inc = {1'b0, cnt} + {{TIMEOUT_W{1'b0}}, 1'b1};
  assign expired = enable && (limit != '0) && (cnt_inc == {1'b0, limit});

endmodule

// File: rtl/tile_sequencer.sv
// Ping-pong tile sequencer for the convolution core.
// Optional RUN watchdog enabled by defining TILE_SEQ_TIMEOUT_EN.
module tile_sequencer
  import tile_seq_pkg::*;
#(
  parameter int unsigned TILE_W    = 16,
  parameter int unsigned TIMEOUT_W = 20
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_soft_reset,
  input  logic                 i_go,
  input  logic [TILE_W-1:0]    i_num_tiles,
  input  logic [TIMEOUT_W-1:0] i_timeout_lim,
  input  logic                 i_buf_ready,
  input  logic                 i_core_done,
  output logic                 o_buf_swap,
  output logic                 o_core_start,
  output logic                 o_core_soft_reset,
  output logic [TILE_W-1:0]    o_tile_idx,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_timeout,
  output logic [2:0]           o_status
);

  seq_state_t        state, state_nx;
  logic [TILE_W-1:0] tile_idx;
  logic [TILE_W-1:0] num_tiles_q;
  logic              soft_q;
  logic              last_tile;
  logic              go_ok;
  logic              expired;

  assign last_tile = (tile_idx == num_tiles_q - 1'b1);
  assign go_ok     = (state == IDLE) && i_go;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (i_go) state_nx = (i_num_tiles == '0) ? FINISH : WAIT_BUF;
      WAIT_BUF: if (i_buf_ready) state_nx = SWAP;
      SWAP:     state_nx = RUN;
      RUN: begin
        if (i_core_done)
          state_nx = last_tile ? FINISH : WAIT_BUF;
        else if (expired)
          state_nx = ABORT;
      end
      FINISH:   state_nx = IDLE;
      ABORT:    state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (i_soft_reset)
      state_nx = IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      tile_idx    <= '0;
      num_tiles_q <= '0;
      soft_q      <= 1'b0;
    end else begin
      state  <= state_nx;
      soft_q <= i_soft_reset;
      if (i_soft_reset) begin
        tile_idx <= '0;
      end else if (go_ok) begin
        num_tiles_q <= i_num_tiles;
        tile_idx    <= '0;
      end else if ((state == RUN) && i_core_done && !last_tile) begin
        tile_idx <= tile_idx + 1'b1;
      end
    end
  end

`ifdef TILE_SEQ_TIMEOUT_EN
  logic timeout_q;

  seq_watchdog #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_watchdog (
    .clk    (i_clk),
    .rst    (i_rst),
    .clear  (state == SWAP),
    .enable (state == RUN),
    .limit  (i_timeout_lim),
    .expired(expired)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      timeout_q <= 1'b0;
    else if (i_soft_reset || go_ok)
      timeout_q <= 1'b0;
    else if (state_nx == ABORT)
      timeout_q <= 1'b1;
  end

  assign o_timeout = timeout_q;
`else
  logic unused_timeout_lim;

  assign unused_timeout_lim = ^i_timeout_lim;
  assign expired            = 1'b0;
  assign o_timeout          = 1'b0;
`endif

  assign o_buf_swap        = (state == SWAP);
  assign o_core_start      = (state == SWAP);
  assign o_core_soft_reset = soft_q || (state == ABORT);
  assign o_tile_idx        = tile_idx;
  assign o_busy            = (state != IDLE);
  assign o_done            = (state == FINISH);
  assign o_status          = state;

endmodule
